// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
//   state_t : sequencing states of serial_addsub
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, used as the per-bit cell of serial_addsub.
//   a, b  : operand bits
//   c     : carry in
//   sum   : sum bit
//   carry : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. One bit per clock, LSB first, WIDTH cycles
// per operation, one shared full_adder with a registered carry.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request; accepted in IDLE or DONE
//   sub        : 0 = a + b + cin, 1 = a - b
//   a, b, cin  : operands, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when sum/cout/ovf update
//   sum        : result, held until the next completion
//   cout       : carry out (for subtract, 1 = no borrow)
//   ovf        : signed overflow
//
// state | meaning
// IDLE  | waiting for start
// ADD   | shifting one bit per clock through the full adder
// DONE  | result just written; start here reloads back-to-back
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B and force the carry in.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          res_sr <= res_next;
          carry  <= fa_carry;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // On the last bit, carry still holds the carry into the MSB.
            sum   <= res_next;
            cout  <= fa_carry;
            ovf   <= carry ^ fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .sub   (sub4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done8; n counts negedges since the start negedge.
  task automatic wait_done8(inout int n);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tsub, input logic tcin,
                         input logic [7:0] es, input logic ec, input logic eo);
    int n;
    a8 = ta; b8 = tb_; sub8 = tsub; cin8 = tcin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ta; b8 = ~tb_; sub8 = ~tsub; cin8 = ~tcin;
    chk({tag, " busy"}, busy8, 1);
    n = 1;
    wait_done8(n);
    chk({tag, " lat"}, n, 9);
    chk({tag, " sum"}, sum8, es);
    chk({tag, " cout"}, cout8, ec);
    chk({tag, " ovf"}, ovf8, eo);
    @(negedge clk);
    chk({tag, " done1"}, done8, 0);
    chk({tag, " idle"}, busy8, 0);
  endtask

  initial begin
    int n;
    logic [3:0] ta, tb_, bb, es;
    logic [4:0] full;
    logic tci, tsub, ci, eo;

    rst_n = 1'b0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst out", {cout8, ovf8, sum8}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op8("add5a3c", 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    run_op8("addff01", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    run_op8("addff01c", 8'hFF, 8'h01, 0, 1, 8'h01, 1, 0);
    run_op8("sub1020", 8'h10, 8'h20, 1, 0, 8'hF0, 0, 0);
    run_op8("sub8001", 8'h80, 8'h01, 1, 1, 8'h7F, 1, 1);

    // start re-pulsed while busy is ignored
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 0; cin8 = 0; start8 = 1;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; sub8 = 1;
    repeat (3) @(negedge clk);
    start8 = 0;
    n = 4;
    wait_done8(n);
    chk("ign lat", n, 9);
    chk("ign sum", {cout8, ovf8, sum8}, {2'b01, 8'h96});
    @(negedge clk);

    // start held through DONE: back-to-back
    a8 = 8'h10; b8 = 8'h20; sub8 = 1; cin8 = 0; start8 = 1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; sub8 = 0; cin8 = 1;
    n = 1;
    wait_done8(n);
    chk("b2b lat1", n, 9);
    chk("b2b res1", {cout8, ovf8, sum8}, {2'b00, 8'hF0});
    @(negedge clk);
    start8 = 0;
    chk("b2b busy", busy8, 1);
    n = 1;
    wait_done8(n);
    chk("b2b lat2", n, 9);
    chk("b2b res2", {cout8, ovf8, sum8}, {2'b10, 8'h01});
    @(negedge clk);

    // reset mid-operation
    a8 = 8'h80; b8 = 8'h01; sub8 = 1; cin8 = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mrst busy", busy8, 0);
    chk("mrst done", done8, 0);
    chk("mrst out", {cout8, ovf8, sum8}, 0);
    rst_n = 1;
    @(negedge clk);
    run_op8("post rst", 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);

    // WIDTH=4 exhaustive
    for (int i = 0; i < 1024; i++) begin
      ta = i[3:0]; tb_ = i[7:4]; tci = i[8]; tsub = i[9];
      bb = tsub ? ~tb_ : tb_;
      ci = tsub ? 1'b1 : tci;
      full = {1'b0, ta} + {1'b0, bb} + {4'b0, ci};
      es = full[3:0];
      eo = (ta[3] == bb[3]) && (es[3] != ta[3]);
      a4 = ta; b4 = tb_; cin4 = tci; sub4 = tsub; start4 = 1;
      @(negedge clk);
      start4 = 0;
      n = 1;
      while (!done4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("w4", {n[7:0], full[4], eo, es}, {8'd5, full[4], eo, es});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
